// File: rtl/fire_weight_bank_loader_pkg.sv
// Shared types and default sizes for the fire weight bank loader and its banks.
package fire_pkg;

    typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DONE} ld_state_t;

    localparam int FIRE_WIDTH = 16;
    localparam int FIRE_ADDR  = 8;
    localparam int FIRE_NUM   = 64;
    localparam int FIRE_DEPTH = 256;

    // Counter width that stays legal when only one item exists.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fire_weight_bank_loader_bank.sv
// One weight bank: synchronous write port, asynchronous read port, no reset on contents.
module fire_weight_bank #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [ADDR-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [ADDR-1:0]  raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    (* ram_style = "distributed", rom_style = "distributed" *)
    logic [WIDTH-1:0] mem_q [0:(2**ADDR)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fire_weight_bank_loader.sv
// Streams one layer's weights, bank-major, into NUM distributed-RAM banks; parallel read view.
module fire_weight_bank_loader
    import fire_pkg::*;
#(
    parameter int WIDTH = FIRE_WIDTH,
    parameter int ADDR  = FIRE_ADDR,
    parameter int NUM   = FIRE_NUM,
    parameter int DEPTH = FIRE_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    input  logic [ADDR-1:0]  address,
    output logic [WIDTH-1:0] rom_out [0:NUM-1],
    output logic             busy,
    output logic             done,
    output logic             load_err
);

    localparam int              BW    = cnt_w(NUM);
    localparam logic [ADDR-1:0] ALAST = ADDR'(DEPTH - 1);
    localparam logic [BW-1:0]   BLAST = BW'(NUM - 1);

    ld_state_t       state_q, state_d;
    logic [BW-1:0]   bcnt_q, bcnt_d;
    logic [ADDR-1:0] acnt_q, acnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic xfer, final_word, wr_en;

    assign xfer       = s_valid && (state_q == LD_LOAD);
    assign final_word = (bcnt_q == BLAST) && (acnt_q == ALAST);
    // An early s_last aborts the load without committing that word.
    assign wr_en      = xfer && (final_word || !s_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
            bcnt_q  <= '0;
            acnt_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            acnt_q  <= acnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        acnt_d  = acnt_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            LD_IDLE, LD_DONE: begin
                if (start) begin
                    state_d = LD_LOAD;
                    bcnt_d  = '0;
                    acnt_d  = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LD_LOAD: begin
                if (xfer) begin
                    if (final_word) begin
                        if (s_last) begin
                            state_d = LD_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = LD_IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (s_last) begin
                        state_d = LD_IDLE;
                        err_d   = 1'b1;
                    end else if (acnt_q == ALAST) begin
                        acnt_d = '0;
                        bcnt_d = bcnt_q + 1'b1;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_comb begin
        s_ready  = (state_q == LD_LOAD);
        busy     = (state_q == LD_LOAD);
        done     = done_q;
        load_err = err_q;
    end

    for (genvar b = 0; b < NUM; b++) begin : g_bank
        fire_weight_bank #(
            .WIDTH (WIDTH),
            .ADDR  (ADDR)
        ) u_bank (
            .clk_i   (clk),
            .we_i    (wr_en && (bcnt_q == BW'(b))),
            .waddr_i (acnt_q),
            .wdata_i (s_data),
            .raddr_i (address),
            .rdata_o (rom_out[b])
        );
    end

endmodule

// File: tb/tb_fire_weight_bank_loader.sv
// Bench for fire_weight_bank_loader: table-driven reads plus randomized loads vs a word-index model.
module tb_fire_weight_bank_loader;

    localparam int W = 16, A = 3, N = 4, D = 8, TOT = N * D;

    logic          clk = 1'b0;
    logic          rst, start, s_valid, s_last;
    logic [W-1:0]  s_data;
    logic          s_ready, busy, done, load_err;
    logic [A-1:0]  address;
    logic [W-1:0]  rom_out [0:N-1];

    fire_weight_bank_loader #(.WIDTH(W), .ADDR(A), .NUM(N), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .address(address), .rom_out(rom_out),
        .busy(busy), .done(done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [A-1:0]    addr;
        logic [N*W-1:0]  exp;
    } vec_t;
    vec_t tbl [D];

    int checks = 0, failures = 0;

    // Reference: bank b, address a holds stream word index b*D+a of the last load that reached it.
    logic [W-1:0] model [0:N-1][0:D-1];
    bit exp_done = 0, exp_err = 0, m_load = 0;
    int m_k = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] packed_out();
        logic [N*W-1:0] v;
        for (int b = 0; b < N; b++) v[b*W +: W] = rom_out[b];
        return v;
    endfunction

    task automatic chk_status(input string tag, input bit ex_busy);
        chk({tag, " busy"}, busy, ex_busy);
        chk({tag, " s_ready"}, s_ready, ex_busy);
        chk({tag, " done"}, done, exp_done);
        chk({tag, " load_err"}, load_err, exp_err);
    endtask

    task automatic chk_mem(input string tag);
        logic [N*W-1:0] e;
        for (int a = 0; a < D; a++) begin
            address = A'(a);
            #1;
            for (int b = 0; b < N; b++) e[b*W +: W] = model[b][a];
            chk($sformatf("%s mem addr%0d", tag, a), packed_out(), e);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (!m_load) begin
            m_load = 1; m_k = 0; exp_done = 0; exp_err = 0;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input bit last, input int gap_pct);
        int g = 0;
        while (gap_pct > 0 && g < 8 && $urandom_range(0, 99) < gap_pct) begin
            s_valid = 1'b0;
            tick();
            g++;
            if (m_load) chk("s_ready during gap", s_ready, 1);
        end
        s_valid = 1'b1; s_data = d; s_last = last;
        chk("s_ready before edge", s_ready, m_load);
        chk("done before edge", done, exp_done);
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        if (m_load) begin
            if (last && m_k != TOT - 1) begin
                exp_err = 1; m_load = 0;
            end else begin
                model[m_k / D][m_k % D] = d;
                if (m_k == TOT - 1) begin
                    m_load = 0;
                    if (last) exp_done = 1; else exp_err = 1;
                end else m_k++;
            end
        end
    endtask

    // n words with data base+k (or random), s_last on index last_at (-1 for never).
    task automatic run_load(input logic [W-1:0] base, input bit rnd, input int last_at,
                            input int gap_pct, input int n, input int start_at);
        do_start();
        chk_status("after start", 1);
        for (int k = 0; k < n; k++) begin
            if (k == start_at) do_start();
            send(rnd ? W'($urandom) : base + W'(k), k == last_at, gap_pct);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < D; a++) begin
            tbl[a].addr = A'(a);
            for (int b = 0; b < N; b++) tbl[a].exp[b*W +: W] = W'(b * D + a);
        end

        rst = 1; start = 0; s_valid = 0; s_last = 0; s_data = '0; address = '0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_status("reset", 0);

        // Idle: valid pulses are not accepted.
        for (int i = 0; i < 3; i++) send(16'hDEAD, i[0], 0);
        chk_status("idle pulses", 0);

        // Back-to-back full load, then table-driven reads.
        run_load(16'h0000, 0, TOT - 1, 0, TOT, -1);
        chk_status("full load", 0);
        foreach (tbl[i]) begin
            address = tbl[i].addr;
            #1;
            chk($sformatf("table addr%0d", i), packed_out(), tbl[i].exp);
        end
        address = 3'd5;
        #1;
        chk("addr5 literal", packed_out(), 64'h001D_0015_000D_0005);

        // DONE ignores stream; reset keeps contents.
        for (int i = 0; i < 3; i++) send(16'hBEEF, 1'b1, 0);
        chk_mem("done pulses");
        rst = 1; #2;
        exp_done = 0; exp_err = 0;
        chk_status("reset after done", 0);
        rst = 0;
        tick();
        chk_mem("after reset");

        // Same stream with gaps; then random data with gaps and an ignored mid-load start.
        run_load(16'h0000, 0, TOT - 1, 40, TOT, -1);
        chk_status("gapped load", 0);
        chk_mem("gapped");
        run_load(16'h0000, 1, TOT - 1, 40, TOT, 17);
        chk_status("random load", 0);
        chk_mem("random");

        // Early s_last on word 10.
        run_load(16'h1000, 0, 10, 0, 11, -1);
        chk_status("early last", 0);
        chk_mem("early last");
        do_start();
        chk_status("start clears err", 1);
        for (int k = 0; k < 3; k++) send(16'h1100 + W'(k), 0, 0);

        // Missing s_last on the final word (restart from LOAD is ignored, so finish this load).
        for (int k = 3; k < TOT; k++) send(16'h2000 + W'(k), 0, 20);
        chk_status("missing last", 0);
        chk_mem("missing last");

        // Async reset mid-load after word 12.
        run_load(16'hB000, 0, -1, 0, 13, -1);
        #2 rst = 1;
        #1;
        m_load = 0; exp_done = 0; exp_err = 0;
        chk_status("mid-load reset", 0);
        #1 rst = 0;
        tick();
        chk_mem("after mid-load reset");
        run_load(16'hA000, 0, TOT - 1, 0, TOT, -1);
        chk_status("reload", 0);
        address = 3'd0;
        #1;
        chk("reload addr0", packed_out(), 64'hA018_A010_A008_A000);
        chk_mem("reload");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
